// File: rtl/mem_line_server_pkg.sv
// Shared definitions for the C2 memory-side line server: bus command codes,
// geometry defaults and the server FSM state type.
package mem_line_server_pkg;

  localparam int BITS_IN_BYTE    = 8;
  localparam int CACHE_LINE_SIZE = 16;
  localparam int DATA2_BUS_SIZE  = 2;
  localparam int ADDR2_BITS      = 15;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_READ_LINE  = 2'd1;
  localparam logic [1:0] C2_WRITE_LINE = 2'd2;
  localparam logic [1:0] C2_RESPONSE   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_WAIT = 3'd2,
    RD_WAIT = 3'd3,
    RD_RESP = 3'd4,
    WR_RESP = 3'd5
  } mem_state_t;

endpackage

// File: rtl/mem_line_server_if.sv
// C2 bus between cache and memory server. The shared cmd/data wires are kept as
// per-side drive values plus server enables, resolved here with server priority.
interface mem_line_server_if import mem_line_server_pkg::*; #(
  parameter int ADDR_BITS = ADDR2_BITS,
  parameter int BUS_BYTES = DATA2_BUS_SIZE
) ();
  localparam int BUS_W = BUS_BYTES * BITS_IN_BYTE;

  logic [ADDR_BITS-1:0] addr_mem;
  logic [1:0]           cache_cmd;
  logic [BUS_W-1:0]     cache_data;
  logic [1:0]           srv_cmd;
  logic [BUS_W-1:0]     srv_data;
  logic                 srv_cmd_oe;
  logic                 srv_data_oe;
  logic                 busy;
  logic [1:0]           cmd_mem;
  logic [BUS_W-1:0]     data_mem;

  // Released server side (oe low) is the 'z state; the cache value then wins.
  assign cmd_mem  = srv_cmd_oe  ? srv_cmd  : cache_cmd;
  assign data_mem = srv_data_oe ? srv_data : cache_data;

  modport master (
    output addr_mem, cache_cmd, cache_data,
    input  cmd_mem, data_mem, busy, srv_cmd_oe, srv_data_oe
  );

  modport slave (
    input  addr_mem, cmd_mem, data_mem,
    output srv_cmd, srv_data, srv_cmd_oe, srv_data_oe, busy
  );
endinterface

// File: rtl/mem_line_server_array.sv
// Line-organised single-port backing store: full-line synchronous write and a
// synchronous read whose result is held until the next read.
module mem_line_server_array #(
  parameter int ADDR_BITS = 15,
  parameter int LINE_W    = 128
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [LINE_W-1:0]    wr_line,
  output logic [LINE_W-1:0]    rd_line
);
  logic [LINE_W-1:0] mem_r [2**ADDR_BITS];

  // Storage access; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_line;
    end
    if (rd_en) begin
      rd_line <= mem_r[addr];
    end
  end
endmodule

// File: rtl/mem_line_server_chk.sv
// Protocol checker: flags a READ/WRITE issued by the cache while the server is
// busy (a WRITE held from the previous cycle is the legal burst continuation).
module mem_line_server_chk import mem_line_server_pkg::*; (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       busy,
  input  logic [1:0] cmd,
  output logic       violation
);
  logic [1:0] cmd_prev_r;

  // Previous cache command, to tell burst continuation from a new request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_prev_r <= C2_NOP;
    end else begin
      cmd_prev_r <= cmd;
    end
  end

  assign violation = busy && ((cmd == C2_READ_LINE) ||
                              ((cmd == C2_WRITE_LINE) && (cmd_prev_r != C2_WRITE_LINE)));

  a_no_cmd_while_busy: assert property (@(posedge clk) disable iff (!reset_n) !violation)
    else $warning("cache command issued while memory server busy");
endmodule

// File: rtl/mem_line_server.sv
// Memory-side C2 line server: whole-line read/write with fixed MEM_LATENCY from
// accept edge to first RESPONSE edge, data moved in BUS_BYTES beats.
module mem_line_server import mem_line_server_pkg::*; #(
  parameter int ADDR_BITS   = ADDR2_BITS,
  parameter int LINE_BYTES  = CACHE_LINE_SIZE,
  parameter int BUS_BYTES   = DATA2_BUS_SIZE,
  parameter int MEM_LATENCY = 100
) (
  input logic              clk,
  input logic              reset_n,
  mem_line_server_if.slave bus
);
  localparam int BEATS  = LINE_BYTES / BUS_BYTES;
  localparam int BUS_W  = BUS_BYTES * BITS_IN_BYTE;
  localparam int LINE_W = LINE_BYTES * BITS_IN_BYTE;
  localparam int LAT_W  = $clog2(MEM_LATENCY + 1);
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  mem_state_t           state_r, state_s;
  logic [LAT_W-1:0]     lat_r, lat_s;
  logic [BEAT_W-1:0]    beat_r, beat_s;
  logic [ADDR_BITS-1:0] addr_r, addr_s, arr_addr_s;
  logic [LINE_W-1:0]    buf_r, buf_s, rd_line_s;
  logic [1:0]           cmd_r, cmd_s;
  logic [BUS_W-1:0]     data_r, data_s;
  logic                 cmd_oe_r, cmd_oe_s, data_oe_r, data_oe_s, busy_r;
  logic                 wr_en_s, rd_en_s;

  // Next state, counters, line buffer and next bus drive values.
  always_comb begin
    state_s   = state_r;
    lat_s     = lat_r;
    beat_s    = beat_r;
    addr_s    = addr_r;
    buf_s     = buf_r;
    cmd_s     = C2_NOP;
    data_s    = '0;
    cmd_oe_s  = 1'b0;
    data_oe_s = 1'b0;
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cmd_mem == C2_READ_LINE) begin
          addr_s  = bus.addr_mem;
          rd_en_s = 1'b1;
          lat_s   = LAT_W'(1);
          state_s = RD_WAIT;
        end else if (bus.cmd_mem == C2_WRITE_LINE) begin
          addr_s             = bus.addr_mem;
          buf_s[BUS_W-1:0]   = bus.data_mem;
          beat_s             = BEAT_W'(1);
          state_s            = WR_DATA;
        end else begin
          state_s = IDLE;
        end
      end
      WR_DATA: begin
        if (bus.cmd_mem == C2_WRITE_LINE) begin
          buf_s[beat_r*BUS_W +: BUS_W] = bus.data_mem;
          if (beat_r == BEAT_LAST) begin
            // The last beat is merged combinationally so the commit lands on this edge.
            wr_en_s = 1'b1;
            beat_s  = '0;
            lat_s   = LAT_W'(1);
            state_s = WR_WAIT;
          end else begin
            beat_s = beat_r + 1'b1;
          end
        end else begin
          beat_s  = '0;
          state_s = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        cmd_oe_s = 1'b1;
        if (lat_r == LAT_LAST) begin
          cmd_s = C2_RESPONSE;
          if (state_r == RD_WAIT) begin
            beat_s    = '0;
            data_s    = rd_line_s[BUS_W-1:0];
            data_oe_s = 1'b1;
            state_s   = RD_RESP;
          end else begin
            state_s = WR_RESP;
          end
        end else begin
          lat_s = lat_r + 1'b1;
          cmd_s = C2_NOP;
        end
      end
      RD_RESP: begin
        if (beat_r == BEAT_LAST) begin
          beat_s  = '0;
          state_s = IDLE;
        end else begin
          beat_s    = beat_r + 1'b1;
          cmd_oe_s  = 1'b1;
          cmd_s     = C2_RESPONSE;
          data_oe_s = 1'b1;
          data_s    = rd_line_s[beat_s*BUS_W +: BUS_W];
        end
      end
      WR_RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered bus drivers; reset releases the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      lat_r     <= '0;
      beat_r    <= '0;
      addr_r    <= '0;
      buf_r     <= '0;
      cmd_r     <= C2_NOP;
      data_r    <= '0;
      cmd_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      lat_r     <= lat_s;
      beat_r    <= beat_s;
      addr_r    <= addr_s;
      buf_r     <= buf_s;
      cmd_r     <= cmd_s;
      data_r    <= data_s;
      cmd_oe_r  <= cmd_oe_s;
      data_oe_r <= data_oe_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign arr_addr_s = wr_en_s ? addr_r : bus.addr_mem;

  mem_line_server_array #(
    .ADDR_BITS (ADDR_BITS),
    .LINE_W    (LINE_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .rd_en   (rd_en_s),
    .addr    (arr_addr_s),
    .wr_line (buf_s),
    .rd_line (rd_line_s)
  );

  assign bus.srv_cmd     = cmd_r;
  assign bus.srv_data    = data_r;
  assign bus.srv_cmd_oe  = cmd_oe_r;
  assign bus.srv_data_oe = data_oe_r;
  assign bus.busy        = busy_r;
endmodule

// File: tb/tb_mem_line_server.sv
// Directed bench for mem_line_server: expected response beats are queued when a
// command is driven and checked as RESPONSE cycles appear on either instance.
module tb_mem_line_server;
  import mem_line_server_pkg::*;

  localparam int BEATS = 8;

  typedef struct {
    int          dut;
    int          edge_n;
    logic [15:0] data;
    logic        is_rd;
  } exp_t;

  logic        clk;
  logic        rst0, rst1;
  int          cyc;
  int          n_cmp;
  int          n_fail;
  int          viol_cnt;
  int          lat[2] = '{100, 2};
  exp_t        q[$];
  exp_t        mon_e;
  logic        viol0;
  logic [14:0] c_addr[2];
  logic [1:0]  c_cmd[2];
  logic [15:0] c_data[2];
  logic        mon_oe[2], mon_doe[2], mon_busy[2];
  logic [1:0]  mon_cmd[2];
  logic [15:0] mon_data[2];

  mem_line_server_if bus0 ();
  mem_line_server_if bus1 ();

  mem_line_server #(.MEM_LATENCY(100)) dut0 (.clk(clk), .reset_n(rst0), .bus(bus0));
  mem_line_server #(.MEM_LATENCY(2))   dut1 (.clk(clk), .reset_n(rst1), .bus(bus1));

  mem_line_server_chk chk0 (
    .clk(clk), .reset_n(rst0), .busy(bus0.busy), .cmd(bus0.cache_cmd), .violation(viol0)
  );

  assign bus0.addr_mem = c_addr[0];
  assign bus0.cache_cmd = c_cmd[0];
  assign bus0.cache_data = c_data[0];
  assign bus1.addr_mem = c_addr[1];
  assign bus1.cache_cmd = c_cmd[1];
  assign bus1.cache_data = c_data[1];
  assign mon_oe[0] = bus0.srv_cmd_oe;
  assign mon_oe[1] = bus1.srv_cmd_oe;
  assign mon_doe[0] = bus0.srv_data_oe;
  assign mon_doe[1] = bus1.srv_data_oe;
  assign mon_cmd[0] = bus0.srv_cmd;
  assign mon_cmd[1] = bus1.srv_cmd;
  assign mon_data[0] = bus0.srv_data;
  assign mon_data[1] = bus1.srv_data;
  assign mon_busy[0] = bus0.busy;
  assign mon_busy[1] = bus1.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (viol0 === 1'b1) viol_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every RESPONSE cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_oe[d] === 1'b1 && mon_cmd[d] === C2_RESPONSE) begin
        chk($sformatf("resp_expected_dut%0d_edge%0d", d, cyc + 1), 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("resp_dut", 32'(d), 32'(mon_e.dut));
          chk("resp_edge", 32'(cyc + 1), 32'(mon_e.edge_n));
          chk("resp_data_oe", 32'(mon_doe[d]), 32'(mon_e.is_rd));
          if (mon_e.is_rd) chk("resp_data", 32'(mon_data[d]), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives nb WRITE beats back to back, then NOP.
  task automatic send_write(input int d, input logic [14:0] a, input logic [15:0] base,
                            input logic [15:0] step, input int nb);
    for (int k = 0; k < nb; k++) begin
      c_cmd[d]  = C2_WRITE_LINE;
      c_addr[d] = a;
      c_data[d] = base + step * 16'(k);
      @(negedge clk);
    end
    c_cmd[d]  = C2_NOP;
    c_data[d] = 16'h0000;
    if (nb == BEATS) q.push_back('{d, cyc + lat[d], 16'h0000, 1'b0});
  endtask

  // Called at a negedge; one READ cycle, then NOP; optionally queues the 8 beats.
  task automatic send_read(input int d, input logic [14:0] a, input logic [15:0] base,
                           input logic [15:0] step, input bit expect_resp);
    logic [15:0] v;
    c_cmd[d]  = C2_READ_LINE;
    c_addr[d] = a;
    @(negedge clk);
    c_cmd[d] = C2_NOP;
    if (expect_resp) begin
      for (int k = 0; k < BEATS; k++) begin
        v = base + step * 16'(k);
        q.push_back('{d, cyc + lat[d] + k, v, 1'b1});
      end
    end
  endtask

  task automatic wait_idle(input int d, input string tag);
    int n;
    n = 0;
    while (mon_busy[d] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < 400), 32'd1);
    chk({tag, "_cmd_released"}, 32'(mon_oe[d]), 32'd0);
    chk({tag, "_data_released"}, 32'(mon_doe[d]), 32'd0);
    chk({tag, "_queue_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; viol_cnt = 0; cyc = 0;
    rst0 = 1'b0; rst1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      c_cmd[d] = C2_NOP; c_addr[d] = 15'h0000; c_data[d] = 16'h0000;
    end
    tick(3);
    chk("reset_busy0", 32'(mon_busy[0]), 32'd0);
    chk("reset_oe0", 32'(mon_oe[0]), 32'd0);
    chk("reset_doe0", 32'(mon_doe[0]), 32'd0);
    chk("reset_busy1", 32'(mon_busy[1]), 32'd0);
    rst0 = 1'b1; rst1 = 1'b1;
    tick(2);

    // 1: write then read back 0x01A3
    send_write(0, 15'h01A3, 16'h0001, 16'h0001, BEATS);
    wait_idle(0, "t1_wr");
    send_read(0, 15'h01A3, 16'h0001, 16'h0001, 1'b1);
    wait_idle(0, "t1_rd");

    // 2: opposite ends of the address space must not alias
    send_write(0, 15'h0000, 16'hFFFF, 16'h0000, BEATS);
    wait_idle(0, "t2_wr0");
    send_write(0, 15'h7FFF, 16'hA5A5, 16'h0000, BEATS);
    wait_idle(0, "t2_wr1");
    send_read(0, 15'h0000, 16'hFFFF, 16'h0000, 1'b1);
    wait_idle(0, "t2_rd0");
    send_read(0, 15'h7FFF, 16'hA5A5, 16'h0000, 1'b1);
    wait_idle(0, "t2_rd1");

    // 3: reset in the middle of a read wait
    send_read(0, 15'h0010, 16'h0000, 16'h0000, 1'b0);
    tick(39);
    chk("t3_busy_before_reset", 32'(mon_busy[0]), 32'd1);
    #1 rst0 = 1'b0;
    #1;
    chk("t3_reset_busy", 32'(mon_busy[0]), 32'd0);
    chk("t3_reset_oe", 32'(mon_oe[0]), 32'd0);
    chk("t3_reset_doe", 32'(mon_doe[0]), 32'd0);
    @(negedge clk);
    rst0 = 1'b1;
    tick(150);
    send_read(0, 15'h01A3, 16'h0001, 16'h0001, 1'b1);
    wait_idle(0, "t3_rd");

    // 4: aborted write leaves the line untouched
    send_write(0, 15'h0020, 16'h2001, 16'h0001, BEATS);
    wait_idle(0, "t4_wr");
    send_write(0, 15'h0020, 16'h9000, 16'h0011, 3);
    tick(1);
    chk("t4_abort_idle", 32'(mon_busy[0]), 32'd0);
    send_read(0, 15'h0020, 16'h2001, 16'h0001, 1'b1);
    wait_idle(0, "t4_rd");

    // 5: a second read while busy is ignored and flagged
    send_write(0, 15'h0001, 16'h1100, 16'h0001, BEATS);
    wait_idle(0, "t5_wr1");
    send_write(0, 15'h0002, 16'h2200, 16'h0001, BEATS);
    wait_idle(0, "t5_wr2");
    chk("t5_no_violation_yet", 32'(viol_cnt), 32'd0);
    send_read(0, 15'h0001, 16'h1100, 16'h0001, 1'b1);
    tick(9);
    c_cmd[0] = C2_READ_LINE;
    c_addr[0] = 15'h0002;
    @(negedge clk);
    c_cmd[0] = C2_NOP;
    wait_idle(0, "t5_rd");
    tick(20);
    chk("t5_violation_flagged", 32'(viol_cnt), 32'd1);
    chk("t5_no_extra_resp", 32'(q.size()), 32'd0);

    // 6: latency-2 instance, write immediately followed by read
    send_write(1, 15'h0005, 16'h0C01, 16'h0101, BEATS);
    wait_idle(1, "t6_wr");
    send_read(1, 15'h0005, 16'h0C01, 16'h0101, 1'b1);
    wait_idle(1, "t6_rd");

    tick(5);
    chk("end_queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
